// File: rtl/dsp_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_cfg_pkg
// Description : MODE_BITS field map, word width and loader FSM states shared
//               by the DSP configuration writer and its packer.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_cfg_pkg;

    localparam int WORD_W    = 72;

    localparam int F_MODE    = 71;
    localparam int REGIN_ALT = 63;
    localparam int REGIN     = 61;
    localparam int SUB       = 58;
    localparam int SAT       = 57;
    localparam int SHR_HI    = 56;
    localparam int SHR_LO    = 51;
    localparam int RND_HI    = 40;
    localparam int RND_LO    = 38;
    localparam int ACCFIR_HI = 37;
    localparam int ACCFIR_LO = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dsp_mode_bits_pack.sv
`default_nettype none
// ============================================================================
// Module      : dsp_mode_bits_pack
// Description : Combinational packer from decoded DSP control fields into the
//               72-bit MODE_BITS word; unlisted bits are zero.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_mode_bits_pack
    import dsp_cfg_pkg::*;
(
    input  logic              f_mode,
    input  logic              register_inputs,
    input  logic              subtract,
    input  logic              saturate_enable,
    input  logic [5:0]        shift_right,
    input  logic [2:0]        round_mode,
    input  logic [5:0]        acc_fir,
    output logic [WORD_W-1:0] mode_bits
);

    always_comb begin
        mode_bits                        = '0;
        mode_bits[F_MODE]                = f_mode;
        mode_bits[REGIN_ALT]             = 1'b0;
        mode_bits[REGIN]                 = register_inputs;
        mode_bits[SUB]                   = subtract;
        mode_bits[SAT]                   = saturate_enable;
        mode_bits[SHR_HI:SHR_LO]         = shift_right;
        mode_bits[RND_HI:RND_LO]         = round_mode;
        mode_bits[ACCFIR_HI:ACCFIR_LO]   = acc_fir;
    end

endmodule
`default_nettype wire

// File: rtl/dsp_mode_bits_writer.sv
`default_nettype none
// ============================================================================
// Module      : dsp_mode_bits_writer
// Description : Packs DSP control fields into MODE_BITS, shifts the word into
//               the DSP configuration chain and pulses a parallel load.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_mode_bits_writer #(
    parameter int WORD_W    = 72,
    parameter int CLK_DIV   = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              f_mode,
    input  logic              register_inputs,
    input  logic              subtract,
    input  logic              saturate_enable,
    input  logic [5:0]        shift_right,
    input  logic [2:0]        round_mode,
    input  logic [5:0]        acc_fir,
    input  logic [2:0]        output_select,
    input  logic              abort,
    output logic              cfg_data,
    output logic              cfg_shift_en,
    output logic              cfg_load,
    output logic [2:0]        output_select_q,
    output logic [WORD_W-1:0] mode_bits_q,
    output logic              done,
    output logic              aborted
);
    import dsp_cfg_pkg::*;

    localparam int              CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
    localparam logic [7:0]      DIV_TC   = 8'(CLK_DIV - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WORD_W-1:0]  r_shreg;
    logic [WORD_W-1:0]  w_shreg_rot;
    logic [WORD_W-1:0]  w_packed;
    logic [2:0]         r_sel_cap;
    logic [7:0]         r_div;
    logic [CNT_W-1:0]   r_bitcnt;
    logic               w_strobe;
    logic               w_ser_bit;

    dsp_mode_bits_pack u_pack (
        .f_mode          (f_mode),
        .register_inputs (register_inputs),
        .subtract        (subtract),
        .saturate_enable (saturate_enable),
        .shift_right     (shift_right),
        .round_mode      (round_mode),
        .acc_fir         (acc_fir),
        .mode_bits       (w_packed)
    );

    // The shift register rotates, so after a full word it holds the packed value again.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_ser_bit   = r_shreg[0];
            assign w_shreg_rot = {r_shreg[0], r_shreg[WORD_W-1:1]};
        end else begin : g_msb_first
            assign w_ser_bit   = r_shreg[WORD_W-1];
            assign w_shreg_rot = {r_shreg[WORD_W-2:0], r_shreg[WORD_W-1]};
        end
    endgenerate

    assign w_strobe = (r_state == ST_SHIFT) && (r_div == DIV_TC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_shreg         <= '0;
            r_sel_cap       <= 3'd0;
            r_div           <= 8'd0;
            r_bitcnt        <= '0;
            mode_bits_q     <= '0;
            output_select_q <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE) begin
                if (req_valid) begin
                    r_shreg   <= w_packed;
                    r_sel_cap <= output_select;
                    r_div     <= 8'd0;
                    r_bitcnt  <= '0;
                end
            end else if (r_state == ST_SHIFT) begin
                if (w_strobe) begin
                    r_shreg  <= w_shreg_rot;
                    r_div    <= 8'd0;
                    r_bitcnt <= r_bitcnt + CNT_W'(1);
                end else begin
                    r_div    <= r_div + 8'd1;
                end
            end else if (r_state == ST_LOAD) begin
                mode_bits_q     <= r_shreg;
                output_select_q <= r_sel_cap;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        req_ready    = 1'b0;
        cfg_shift_en = 1'b0;
        cfg_data     = 1'b0;
        cfg_load     = 1'b0;
        done         = 1'b0;
        aborted      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cfg_shift_en = w_strobe;
                cfg_data     = w_strobe & w_ser_bit;
                // Abort takes priority even over the final strobe.
                if (abort) begin
                    aborted     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_strobe && (r_bitcnt == CNT_LAST)) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cfg_load    = 1'b1;
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dsp_mode_bits_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_mode_bits_writer
// Description : Self-checking bench for the MODE_BITS writer (divide-by-1 and
//               divide-by-4 instances) against a field-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_mode_bits_writer;

    typedef struct {
        bit       fm;
        bit       ri;
        bit       sb;
        bit       st;
        bit [5:0] shr;
        bit [2:0] rnd;
        bit [5:0] acc;
        bit [2:0] sel;
    } fld_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rv1 = 1'b0, rv4 = 1'b0, abort1 = 1'b0, abort4 = 1'b0;
    logic       f_mode = 1'b0, register_inputs = 1'b0, subtract = 1'b0, saturate_enable = 1'b0;
    logic [5:0] shift_right = '0, acc_fir = '0;
    logic [2:0] round_mode = '0, output_select = '0;

    logic        rdy1, dat1, sen1, ld1, dn1, ab1;
    logic        rdy4, dat4, sen4, ld4, dn4, ab4;
    logic [2:0]  sq1, sq4;
    logic [71:0] mb1, mb4;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dsp_mode_bits_writer #(.WORD_W(72), .CLK_DIV(1), .LSB_FIRST(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(rdy1),
        .f_mode(f_mode), .register_inputs(register_inputs), .subtract(subtract),
        .saturate_enable(saturate_enable), .shift_right(shift_right), .round_mode(round_mode),
        .acc_fir(acc_fir), .output_select(output_select), .abort(abort1),
        .cfg_data(dat1), .cfg_shift_en(sen1), .cfg_load(ld1), .output_select_q(sq1),
        .mode_bits_q(mb1), .done(dn1), .aborted(ab1)
    );

    dsp_mode_bits_writer #(.WORD_W(72), .CLK_DIV(4), .LSB_FIRST(1)) u_dut4 (
        .clk(clk), .reset(reset), .req_valid(rv4), .req_ready(rdy4),
        .f_mode(f_mode), .register_inputs(register_inputs), .subtract(subtract),
        .saturate_enable(saturate_enable), .shift_right(shift_right), .round_mode(round_mode),
        .acc_fir(acc_fir), .output_select(output_select), .abort(abort4),
        .cfg_data(dat4), .cfg_shift_en(sen4), .cfg_load(ld4), .output_select_q(sq4),
        .mode_bits_q(mb4), .done(dn4), .aborted(ab4)
    );

    // Reference packing: each field weighted by 2**(its low bit position).
    function automatic logic [71:0] model(input fld_t f);
        logic [71:0] v;
        v = '0;
        v = v + (72'(f.fm)  << 71);
        v = v + (72'(f.ri)  << 61);
        v = v + (72'(f.sb)  << 58);
        v = v + (72'(f.st)  << 57);
        v = v + (72'(f.shr) << 51);
        v = v + (72'(f.rnd) << 38);
        v = v + (72'(f.acc) << 32);
        return v;
    endfunction

    function automatic fld_t rand_fld();
        fld_t f;
        f.fm  = 1'($urandom);
        f.ri  = 1'($urandom);
        f.sb  = 1'($urandom);
        f.st  = 1'($urandom);
        f.shr = 6'($urandom);
        f.rnd = 3'($urandom);
        f.acc = 6'($urandom);
        f.sel = 3'($urandom);
        return f;
    endfunction

    task automatic apply(input fld_t f);
        f_mode = f.fm; register_inputs = f.ri; subtract = f.sb; saturate_enable = f.st;
        shift_right = f.shr; round_mode = f.rnd; acc_fir = f.acc; output_select = f.sel;
    endtask

    // Waits for IDLE, presents one request; t_acc is the cycle carrying the accepted request.
    task automatic issue(input bit d4, input bit with_abort, output int t_acc, output bit timeout);
        timeout = 1'b1;
        t_acc = cyc;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if ((d4 ? rdy4 : rdy1) === 1'b1) begin
                timeout = 1'b0;
                break;
            end
        end
        t_acc = cyc;
        if (d4) rv4 = 1'b1; else rv1 = 1'b1;
        if (with_abort) begin
            if (d4) abort4 = 1'b1; else abort1 = 1'b1;
        end
        @(posedge clk);
        #1;
        rv1 = 1'b0; rv4 = 1'b0; abort1 = 1'b0; abort4 = 1'b0;
    endtask

    // Captures the serial stream until cfg_load, or aborts on strobe number abort_at.
    task automatic collect(input bit d4, input int t_acc, input int abort_at,
                           output logic [71:0] word, output int nstb, output int t_load,
                           output bit saw_abort, output bit spacing_ok, output bit done_ok,
                           output bit timeout);
        int div;
        div = d4 ? 4 : 1;
        word = '0; nstb = 0; t_load = -1; saw_abort = 1'b0;
        spacing_ok = 1'b1; done_ok = 1'b1; timeout = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if ((d4 ? dn4 : dn1) !== (d4 ? ld4 : ld1)) done_ok = 1'b0;
            if ((d4 ? sen4 : sen1) === 1'b1) begin
                if (nstb < 72) word[nstb] = d4 ? dat4 : dat1;
                if (((cyc - t_acc) % div) != 0) spacing_ok = 1'b0;
                nstb++;
                if (nstb == abort_at) begin
                    if (d4) abort4 = 1'b1; else abort1 = 1'b1;
                    #1;
                    saw_abort = (d4 ? ab4 : ab1) === 1'b1;
                    if ((d4 ? ld4 : ld1) === 1'b1) done_ok = 1'b0;
                    @(posedge clk);
                    #1;
                    abort1 = 1'b0; abort4 = 1'b0;
                    timeout = 1'b0;
                    return;
                end
            end
            if ((d4 ? ld4 : ld1) === 1'b1) begin
                t_load = cyc;
                timeout = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checks++;
            if ({rdy1, sen1, dat1, ld1, dn1, ab1, sq1, rdy4, sen4, dat4, ld4, dn4, ab4, sq4} !==
                {1'b1, 5'b0, 3'b0, 1'b1, 5'b0, 3'b0} || mb1 !== '0 || mb4 !== '0) begin
                failures++;
                $display("FAIL reset_idle cycle %0d: got r1=%b s1=%b d1=%b l1=%b mb1=%h r4=%b s4=%b l4=%b mb4=%h expected ready=1 others 0",
                         k, rdy1, sen1, dat1, ld1, mb1, rdy4, sen4, ld4, mb4);
            end
        end
    endtask

    task automatic test_basic();
        fld_t f;
        int t_acc, nstb, t_load;
        bit to1, to2, sab, sp, dok;
        logic [71:0] w, exp_w;
        f = '{fm:1'b1, ri:1'b0, sb:1'b0, st:1'b0, shr:6'h2A, rnd:3'b101, acc:6'h15, sel:3'b101};
        apply(f);
        exp_w = 72'h80_0150_0155_0000_0000;
        issue(1'b0, 1'b0, t_acc, to1);
        collect(1'b0, t_acc, 0, w, nstb, t_load, sab, sp, dok, to2);
        checks++;
        if (to1 || to2) begin failures++; $display("FAIL basic_timeout got to=%b%b expected 00", to1, to2); end
        checks++;
        if (nstb !== 72) begin failures++; $display("FAIL basic_strobes got %0d expected 72", nstb); end
        checks++;
        if (w !== exp_w || w !== model(f)) begin
            failures++; $display("FAIL basic_word got %h expected %h", w, exp_w);
        end
        checks++;
        if (t_load - t_acc !== 73) begin failures++; $display("FAIL basic_latency got %0d expected 73", t_load - t_acc); end
        checks++;
        if (!sp || !dok) begin failures++; $display("FAIL basic_strobe_done got sp=%b done_ok=%b expected 1 1", sp, dok); end
        @(negedge clk);
        checks++;
        if (rdy1 !== 1'b1 || cyc - t_acc !== 74) begin
            failures++; $display("FAIL basic_ready got rdy=%b at +%0d expected 1 at +74", rdy1, cyc - t_acc);
        end
        checks++;
        if (mb1 !== exp_w || sq1 !== 3'b101) begin
            failures++; $display("FAIL basic_readback got mb=%h sel=%b expected %h 101", mb1, sq1, exp_w);
        end
    endtask

    task automatic test_div4();
        fld_t f;
        int t_acc, nstb, t_load;
        bit to1, to2, sab, sp, dok;
        logic [71:0] w;
        f = '{fm:1'b0, ri:1'b1, sb:1'b0, st:1'b0, shr:6'h0, rnd:3'b0, acc:6'h0, sel:3'b0};
        apply(f);
        issue(1'b1, 1'b0, t_acc, to1);
        collect(1'b1, t_acc, 0, w, nstb, t_load, sab, sp, dok, to2);
        checks++;
        if (to1 || to2 || nstb !== 72) begin
            failures++; $display("FAIL div4_strobes got n=%0d to=%b%b expected 72 00", nstb, to1, to2);
        end
        checks++;
        if (!sp) begin failures++; $display("FAIL div4_spacing got off-grid strobe expected every 4th cycle"); end
        checks++;
        if (w !== (72'd1 << 61) || w !== model(f)) begin
            failures++; $display("FAIL div4_word got %h expected %h", w, 72'd1 << 61);
        end
        checks++;
        if (t_load - t_acc !== 289) begin failures++; $display("FAIL div4_latency got %0d expected 289", t_load - t_acc); end
        @(negedge clk);
        checks++;
        if (mb4 !== model(f)) begin failures++; $display("FAIL div4_readback got %h expected %h", mb4, model(f)); end
    endtask

    task automatic run_abort(input int at);
        fld_t f;
        int t_acc, nstb, t_load;
        bit to1, to2, sab, sp, dok, saw_load;
        logic [71:0] w, prev_mb;
        logic [2:0] prev_sq;
        prev_mb = mb1;
        prev_sq = sq1;
        f = rand_fld();
        f.fm = ~prev_mb[71];
        apply(f);
        issue(1'b0, 1'b0, t_acc, to1);
        collect(1'b0, t_acc, at, w, nstb, t_load, sab, sp, dok, to2);
        checks++;
        if (to1 || to2 || !sab || !dok) begin
            failures++; $display("FAIL abort%0d_pulse got aborted=%b no_load=%b to=%b%b expected 1 1 00", at, sab, dok, to1, to2);
        end
        saw_load = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy1 !== 1'b1 || ab1 !== 1'b0) begin
            failures++; $display("FAIL abort%0d_ready got rdy=%b ab=%b expected 1 0", at, rdy1, ab1);
        end
        for (int k = 0; k < 80; k++) begin
            if (ld1 === 1'b1 || sen1 === 1'b1) saw_load = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_load || mb1 !== prev_mb || sq1 !== prev_sq) begin
            failures++; $display("FAIL abort%0d_keep got load=%b mb=%h sel=%b expected 0 %h %b", at, saw_load, mb1, sq1, prev_mb, prev_sq);
        end
    endtask

    task automatic test_abort();
        run_abort(10);
        run_abort(72);
    endtask

    task automatic test_back_to_back();
        fld_t a, b;
        int t_acc, t_acc2, nstb, t_load;
        bit to, sab, sp, dok;
        logic [71:0] w;
        a = rand_fld();
        b = rand_fld();
        b.acc = ~a.acc;
        apply(a);
        for (int k = 0; k < 200 && rdy1 !== 1'b1; k++) @(negedge clk);
        t_acc = cyc;
        rv1 = 1'b1;
        @(posedge clk);
        #1;
        apply(b);
        collect(1'b0, t_acc, 0, w, nstb, t_load, sab, sp, dok, to);
        checks++;
        if (to || w !== model(a) || t_load - t_acc !== 73) begin
            failures++; $display("FAIL b2b_first got %h lat=%0d expected %h lat=73", w, t_load - t_acc, model(a));
        end
        @(negedge clk);
        checks++;
        if (rdy1 !== 1'b1 || mb1 !== model(a) || sq1 !== a.sel) begin
            failures++; $display("FAIL b2b_first_load got rdy=%b mb=%h sel=%b expected 1 %h %b", rdy1, mb1, sq1, model(a), a.sel);
        end
        t_acc2 = cyc;
        @(posedge clk);
        #1;
        rv1 = 1'b0;
        collect(1'b0, t_acc2, 0, w, nstb, t_load, sab, sp, dok, to);
        checks++;
        if (to || w !== model(b) || t_load - t_acc2 !== 73) begin
            failures++; $display("FAIL b2b_second got %h lat=%0d expected %h lat=73", w, t_load - t_acc2, model(b));
        end
        @(negedge clk);
        checks++;
        if (mb1 !== model(b) || sq1 !== b.sel) begin
            failures++; $display("FAIL b2b_second_load got mb=%h sel=%b expected %h %b", mb1, sq1, model(b), b.sel);
        end
    endtask

    task automatic test_reset_mid();
        fld_t f;
        int t_acc, nstb, t_load, cnt;
        bit to1, to2, sab, sp, dok;
        logic [71:0] w;
        f = rand_fld();
        f.fm = 1'b1;
        apply(f);
        issue(1'b0, 1'b0, t_acc, to1);
        cnt = 0;
        for (int k = 0; k < 200 && cnt < 40; k++) begin
            @(negedge clk);
            if (sen1 === 1'b1) cnt++;
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({rdy1, sen1, dat1, ld1, dn1, ab1, sq1} !== {1'b1, 5'b0, 3'b0} || mb1 !== '0 || mb4 !== '0 || cnt != 40) begin
            failures++; $display("FAIL reset_mid got rdy=%b sen=%b ld=%b sel=%b mb1=%h mb4=%h strobes=%0d expected 1 0 0 0 0 0 40",
                                 rdy1, sen1, ld1, sq1, mb1, mb4, cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        f = rand_fld();
        apply(f);
        issue(1'b0, 1'b0, t_acc, to1);
        collect(1'b0, t_acc, 0, w, nstb, t_load, sab, sp, dok, to2);
        @(negedge clk);
        checks++;
        if (to1 || to2 || w !== model(f) || mb1 !== model(f) || t_load - t_acc !== 73) begin
            failures++; $display("FAIL reset_recover got w=%h mb=%h lat=%0d expected %h lat=73", w, mb1, t_load - t_acc, model(f));
        end
    endtask

    task automatic test_random();
        fld_t f, junk;
        int t_acc, nstb, t_load;
        bit to1, to2, sab, sp, dok;
        logic [71:0] w;
        for (int i = 0; i < 4; i++) begin
            f = rand_fld();
            apply(f);
            issue(1'b0, (i % 2) == 1, t_acc, to1);
            junk = rand_fld();
            apply(junk);
            collect(1'b0, t_acc, 0, w, nstb, t_load, sab, sp, dok, to2);
            @(negedge clk);
            checks++;
            if (to1 || to2 || nstb !== 72 || w !== model(f) || mb1 !== model(f) || sq1 !== f.sel) begin
                failures++; $display("FAIL random%0d got w=%h mb=%h sel=%b n=%0d expected %h %b 72",
                                     i, w, mb1, sq1, nstb, model(f), f.sel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div4();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
